count_up_to_limit: RTL

- Two-digit BCD up-counter (tens, units) built as a cascaded pair of digit stages with a units-to-tens carry.
- Counts from 00 toward a programmable limit, one step per `increment` pulse.
- Either wraps to 00 with a carry pulse or saturates at the limit.
- Counterpart of the countdown timer: provides elapsed-time / up-count display digits for the same display path.

---
 rtl/count_up_to_limit_if.sv | 22 ++
 rtl/count_up_to_limit.sv | 92 +++++++++
 2 files changed

// File: rtl/count_up_to_limit_if.sv
// rtl/count_up_to_limit_if.sv - control and display-digit bundle for the BCD up-counter.
interface count_up_to_limit_if;
  logic       reconfig;
  logic [3:0] setLimit_tens;
  logic [3:0] setLimit_units;
  logic       increment;
  logic       reset_timer;
  logic [3:0] digit_tens;
  logic [3:0] digit_units;
  logic       at_limit;
  logic       carry_out;

  modport master (
    output reconfig, setLimit_tens, setLimit_units, increment, reset_timer,
    input  digit_tens, digit_units, at_limit, carry_out
  );

  modport slave (
    input  reconfig, setLimit_tens, setLimit_units, increment, reset_timer,
    output digit_tens, digit_units, at_limit, carry_out
  );
endinterface

// File: rtl/count_up_to_limit.sv
// rtl/count_up_to_limit.sv - two-digit BCD up-counter toward a programmable limit.
// Units and tens stages cascade through an internal carry; wraps with a pulse or saturates.
module count_up_to_limit #(
  parameter bit          WRAP              = 1'b1,
  parameter int unsigned RESET_LIMIT_TENS  = 9,
  parameter int unsigned RESET_LIMIT_UNITS = 9
) (
  input logic                 clk,
  input logic                 reset,
  count_up_to_limit_if.slave  bus
);

  localparam logic [3:0] RST_LIM_TENS  = 4'(RESET_LIMIT_TENS);
  localparam logic [3:0] RST_LIM_UNITS = 4'(RESET_LIMIT_UNITS);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [3:0] lim_tens_q, lim_tens_d;
  logic [3:0] lim_units_q, lim_units_d;
  logic       carry_q, carry_d;

  logic [3:0] units_inc;
  logic [3:0] tens_inc;
  logic       units_carry;
  logic       at_limit;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Units stage feeds its rollover into the tens stage.
  always_comb begin
    units_carry = (units_q == 4'd9);
    units_inc   = units_carry ? 4'd0 : units_q + 4'd1;
    tens_inc    = tens_q;
    if (units_carry) begin
      tens_inc = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
    end
  end

  assign at_limit = (tens_q == lim_tens_q) && (units_q == lim_units_q);

  always_comb begin
    tens_d      = tens_q;
    units_d     = units_q;
    lim_tens_d  = lim_tens_q;
    lim_units_d = lim_units_q;
    carry_d     = 1'b0;
    if (bus.reconfig) begin
      lim_tens_d  = clamp_bcd(bus.setLimit_tens);
      lim_units_d = clamp_bcd(bus.setLimit_units);
      tens_d      = 4'd0;
      units_d     = 4'd0;
    end else if (bus.reset_timer) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (bus.increment) begin
      if (at_limit) begin
        if (WRAP) begin
          tens_d  = 4'd0;
          units_d = 4'd0;
          carry_d = 1'b1;
        end
      end else begin
        tens_d  = tens_inc;
        units_d = units_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q      <= 4'd0;
      units_q     <= 4'd0;
      lim_tens_q  <= RST_LIM_TENS;
      lim_units_q <= RST_LIM_UNITS;
      carry_q     <= 1'b0;
    end else begin
      tens_q      <= tens_d;
      units_q     <= units_d;
      lim_tens_q  <= lim_tens_d;
      lim_units_q <= lim_units_d;
      carry_q     <= carry_d;
    end
  end

  assign bus.digit_tens  = tens_q;
  assign bus.digit_units = units_q;
  assign bus.at_limit    = at_limit;
  assign bus.carry_out   = carry_q;

endmodule
